// File: rtl/test_monitor_pkg.sv
// Shared definitions for the test status monitor: hart state codes,
// test-protocol register indices and the jump-trace record layout.
package test_monitor_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } hart_state_e;

  localparam int unsigned DONE_REG_IDX    = 26;
  localparam int unsigned PASS_REG_IDX    = 27;
  localparam int unsigned TESTNUM_REG_IDX = 3;

  typedef struct packed {
    logic [2:0]  hart;
    logic [31:0] from_pc;
    logic [31:0] to_pc;
  } trace_rec_t;

  localparam int unsigned TRACE_REC_W = $bits(trace_rec_t);

  function automatic logic is_terminal(hart_state_e s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/test_status_monitor_trace_fifo.sv
// Jump-trace FIFO: power-of-two depth, pointers carry an extra wrap bit so
// full and empty are distinguishable. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise it is reported lost.
module trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             valid,
  output logic             push_drop,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty;
  logic             full;
  logic             pop;
  logic             wr_en;

  // Occupancy decode, handshake and pointer advance; clear empties the FIFO.
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop       = !empty && pop_ready;
    wr_en     = push && (!full || pop);
    push_drop = push && full && !pop;
    wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Head is shown only while valid so an empty FIFO presents all-zero data.
  always_comb begin
    valid = !empty;
    head  = valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Record storage; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/test_status_monitor.sv
// Test status monitor: follows each hart through the done/pass/testnum
// register protocol, applies a shared run-time timeout and records taken
// jumps of running harts into a trace FIFO with a saturating loss counter.
module test_status_monitor
  import test_monitor_pkg::*;
#(
  parameter int unsigned NUM_HARTS      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned SETTLE_CYCLES  = 5,
  parameter int unsigned DONE_REG       = DONE_REG_IDX,
  parameter int unsigned PASS_REG       = PASS_REG_IDX,
  parameter int unsigned TESTNUM_REG    = TESTNUM_REG_IDX,
  parameter int unsigned TRACE_DEPTH    = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clear,
  input  logic [NUM_HARTS-1:0]    wb_en,
  input  logic [NUM_HARTS*5-1:0]  wb_addr,
  input  logic [NUM_HARTS*32-1:0] wb_data,
  input  logic [NUM_HARTS-1:0]    jump,
  input  logic [NUM_HARTS*32-1:0] jump_from,
  input  logic [NUM_HARTS*32-1:0] jump_to,
  output logic [NUM_HARTS*3-1:0]  hart_state,
  output logic [NUM_HARTS*32-1:0] hart_testnum,
  output logic                   all_done,
  output logic                   all_pass,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [2:0]             trace_hart,
  output logic [31:0]            trace_from,
  output logic [31:0]            trace_to,
  output logic [15:0]            trace_drops
);

  localparam logic [4:0]  DONE_A      = 5'(DONE_REG);
  localparam logic [4:0]  PASS_A      = 5'(PASS_REG);
  localparam logic [4:0]  TNUM_A      = 5'(TESTNUM_REG);
  localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam int unsigned SW          = (SETTLE_LAST > 0) ? $clog2(SETTLE_LAST + 1) : 1;

  hart_state_e    st_q      [NUM_HARTS];
  hart_state_e    st_d      [NUM_HARTS];
  logic [SW-1:0]  settle_q  [NUM_HARTS];
  logic [SW-1:0]  settle_d  [NUM_HARTS];
  logic           pass_ok_q [NUM_HARTS];
  logic           pass_ok_d [NUM_HARTS];
  logic [31:0]    tnum_q    [NUM_HARTS];
  logic [31:0]    tnum_d    [NUM_HARTS];
  logic [31:0]    cyc_q, cyc_d;
  logic [15:0]    drops_q, drops_d;

  logic [4:0]     addr_h    [NUM_HARTS];
  logic [31:0]    data_h    [NUM_HARTS];
  logic [31:0]    jfrom_h   [NUM_HARTS];
  logic [31:0]    jto_h     [NUM_HARTS];

  logic           any_run;
  logic           timeout_hit;
  logic           push;
  trace_rec_t     push_rec;
  logic [3:0]     lost_cnt;
  logic           fifo_drop;
  trace_rec_t     head_rec;
  logic [16:0]    drops_sum;

  // Split the flat per-hart buses and pack per-hart state back out.
  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart_io
    assign addr_h[g]                = wb_addr[g*5 +: 5];
    assign data_h[g]                = wb_data[g*32 +: 32];
    assign jfrom_h[g]               = jump_from[g*32 +: 32];
    assign jto_h[g]                 = jump_to[g*32 +: 32];
    assign hart_state[g*3 +: 3]     = st_q[g];
    assign hart_testnum[g*32 +: 32] = tnum_q[g];
  end

  // Summary flags over all harts.
  always_comb begin
    any_run  = 1'b0;
    all_done = 1'b1;
    all_pass = 1'b1;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      if (st_q[h] == ST_RUN)   any_run  = 1'b1;
      if (!is_terminal(st_q[h])) all_done = 1'b0;
      if (st_q[h] != ST_PASS)  all_pass = 1'b0;
    end
  end

  // Shared run-time counter: counts while anyone runs, saturates at all-ones.
  always_comb begin
    timeout_hit = (cyc_q >= 32'(TIMEOUT_CYCLES));
    cyc_d       = cyc_q;
    if (any_run && (cyc_q != '1)) cyc_d = cyc_q + 32'd1;
    if (clear) cyc_d = '0;
  end

  // Per-hart protocol FSM and register shadows. The verdict samples the
  // pass shadow as held at the start of the final settle cycle.
  always_comb begin
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      st_d[h]      = st_q[h];
      settle_d[h]  = settle_q[h];
      pass_ok_d[h] = pass_ok_q[h];
      tnum_d[h]    = tnum_q[h];

      if ((st_q[h] == ST_RUN || st_q[h] == ST_SETTLE) && wb_en[h] && (addr_h[h] != 5'd0)) begin
        if (addr_h[h] == PASS_A) pass_ok_d[h] = (data_h[h] == 32'd1);
        if (addr_h[h] == TNUM_A) tnum_d[h]    = data_h[h];
      end

      case (st_q[h])
        ST_RUN: begin
          if (wb_en[h] && (addr_h[h] == DONE_A) && (data_h[h] == 32'd1)) begin
            st_d[h]     = ST_SETTLE;
            settle_d[h] = '0;
          end else if (timeout_hit) begin
            st_d[h] = ST_TIMEOUT;
          end
        end
        ST_SETTLE: begin
          if (settle_q[h] == SW'(SETTLE_LAST)) begin
            st_d[h] = pass_ok_q[h] ? ST_PASS : ST_FAIL;
          end else begin
            settle_d[h] = settle_q[h] + 1'b1;
          end
        end
        default: ;
      endcase

      if (clear) begin
        st_d[h]      = ST_RUN;
        settle_d[h]  = '0;
        pass_ok_d[h] = 1'b0;
        tnum_d[h]    = '0;
      end
    end
  end

  // Trace arbitration: lowest running hart with a jump wins, the rest are lost.
  always_comb begin
    push     = 1'b0;
    push_rec = '0;
    lost_cnt = '0;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      if (jump[h] && (st_q[h] == ST_RUN)) begin
        if (!push) begin
          push             = 1'b1;
          push_rec.hart    = 3'(h);
          push_rec.from_pc = jfrom_h[h];
          push_rec.to_pc   = jto_h[h];
        end else begin
          lost_cnt = lost_cnt + 4'd1;
        end
      end
    end
  end

  // Saturating loss counter: arbitration losers plus a full-FIFO rejection.
  always_comb begin
    drops_sum = {1'b0, drops_q} + 17'(lost_cnt) + 17'(fifo_drop);
    drops_d   = drops_sum[16] ? '1 : drops_sum[15:0];
    if (clear) drops_d = '0;
  end

  trace_fifo #(
    .WIDTH (TRACE_REC_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .push      (push),
    .push_data (push_rec),
    .pop_ready (trace_ready),
    .valid     (trace_valid),
    .push_drop (fifo_drop),
    .head      (head_rec)
  );

  assign trace_hart  = head_rec.hart;
  assign trace_from  = head_rec.from_pc;
  assign trace_to    = head_rec.to_pc;
  assign trace_drops = drops_q;

  // State registers for the hart FSMs, shared counter and loss counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        st_q[h]      <= ST_RUN;
        settle_q[h]  <= '0;
        pass_ok_q[h] <= 1'b0;
        tnum_q[h]    <= '0;
      end
      cyc_q   <= '0;
      drops_q <= '0;
    end else begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        st_q[h]      <= st_d[h];
        settle_q[h]  <= settle_d[h];
        pass_ok_q[h] <= pass_ok_d[h];
        tnum_q[h]    <= tnum_d[h];
      end
      cyc_q   <= cyc_d;
      drops_q <= drops_d;
    end
  end

endmodule

// File: tb/tb_test_status_monitor.sv
// Bench for test_status_monitor: constant-expectation table, directed
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_test_status_monitor;

  localparam int NH = 2;
  localparam int TO = 50;
  localparam int SC = 5;
  localparam int TD = 4;

  localparam int S_RUN = 0, S_SET = 1, S_PASS = 2, S_FAIL = 3, S_TMO = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          clear;
  logic [NH-1:0]    wb_en;
  logic [NH*5-1:0]  wb_addr;
  logic [NH*32-1:0] wb_data;
  logic [NH-1:0]    jump;
  logic [NH*32-1:0] jump_from;
  logic [NH*32-1:0] jump_to;
  logic [NH*3-1:0]  hart_state;
  logic [NH*32-1:0] hart_testnum;
  logic          all_done, all_pass;
  logic          trace_valid, trace_ready;
  logic [2:0]    trace_hart;
  logic [31:0]   trace_from, trace_to;
  logic [15:0]   trace_drops;

  int checks = 0;
  int errors = 0;

  test_status_monitor #(
    .NUM_HARTS      (NH),
    .TIMEOUT_CYCLES (TO),
    .SETTLE_CYCLES  (SC),
    .TRACE_DEPTH    (TD)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .clear        (clear),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .jump         (jump),
    .jump_from    (jump_from),
    .jump_to      (jump_to),
    .hart_state   (hart_state),
    .hart_testnum (hart_testnum),
    .all_done     (all_done),
    .all_pass     (all_pass),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace_hart   (trace_hart),
    .trace_from   (trace_from),
    .trace_to     (trace_to),
    .trace_drops  (trace_drops)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          hart;
    logic [31:0] f;
    logic [31:0] t;
  } rec_t;

  int          m_st   [NH];
  int          m_left [NH];
  bit          m_pok  [NH];
  logic [31:0] m_tn   [NH];
  longint      m_cyc;
  int          m_drops;
  rec_t        m_q[$];

  task automatic model_reset();
    for (int h = 0; h < NH; h++) begin
      m_st[h] = S_RUN; m_left[h] = 0; m_pok[h] = 0; m_tn[h] = 0;
    end
    m_cyc = 0; m_drops = 0; m_q.delete();
  endtask

  task automatic model_step();
    int   old_st [NH];
    int   cands[$];
    bit   any_run;
    int   lost;
    rec_t r;
    any_run = 0;
    for (int h = 0; h < NH; h++) begin
      old_st[h] = m_st[h];
      if (m_st[h] == S_RUN) any_run = 1;
      if (jump[h] && m_st[h] == S_RUN) cands.push_back(h);
    end
    // trace: a pop frees a slot before this cycle's record is considered
    if (m_q.size() != 0 && trace_ready) r = m_q.pop_front();
    lost = 0;
    if (cands.size() != 0) begin
      lost = cands.size() - 1;
      if (m_q.size() < TD) begin
        r.hart = cands[0];
        r.f = jump_from[cands[0]*32 +: 32];
        r.t = jump_to[cands[0]*32 +: 32];
        m_q.push_back(r);
      end else lost++;
    end
    m_drops = (m_drops + lost > 65535) ? 65535 : m_drops + lost;
    for (int h = 0; h < NH; h++) begin
      logic [4:0]  a;
      logic [31:0] d;
      a = wb_addr[h*5 +: 5];
      d = wb_data[h*32 +: 32];
      if (m_st[h] == S_RUN) begin
        if (wb_en[h] && a == 5'd26 && d == 32'd1) begin
          m_st[h] = S_SET; m_left[h] = SC;
        end else if (m_cyc >= TO) m_st[h] = S_TMO;
      end else if (m_st[h] == S_SET) begin
        m_left[h]--;
        if (m_left[h] == 0) m_st[h] = m_pok[h] ? S_PASS : S_FAIL;
      end
      if ((old_st[h] == S_RUN || old_st[h] == S_SET) && wb_en[h] && a != 5'd0) begin
        if (a == 5'd27) m_pok[h] = (d == 32'd1);
        if (a == 5'd3)  m_tn[h]  = d;
      end
    end
    if (any_run && m_cyc < 64'hFFFF_FFFF) m_cyc++;
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn || clear) model_reset();
    else model_step();
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 0; wb_en = '0; wb_addr = '0; wb_data = '0;
    jump = '0; jump_from = '0; jump_to = '0; trace_ready = 0;
  endtask

  task automatic wr(input int h, input int a, input logic [31:0] d);
    wb_en[h] = 1'b1;
    wb_addr[h*5 +: 5] = 5'(a);
    wb_data[h*32 +: 32] = d;
  endtask

  task automatic jmp(input int h, input logic [31:0] f, input logic [31:0] t);
    jump[h] = 1'b1;
    jump_from[h*32 +: 32] = f;
    jump_to[h*32 +: 32] = t;
  endtask

  task automatic do_clear();
    idle();
    clear = 1;
    tick();
    clear = 0;
  endtask

  task automatic check_states(input string tag, input int s0, input int s1);
    chk({tag, "_st0"}, hart_state[2:0], s0);
    chk({tag, "_st1"}, hart_state[5:3], s1);
  endtask

  task automatic check_model();
    bit done_e, pass_e;
    done_e = 1; pass_e = 1;
    for (int h = 0; h < NH; h++) begin
      chk("rnd_state", hart_state[h*3 +: 3], m_st[h]);
      chk("rnd_testnum", hart_testnum[h*32 +: 32], m_tn[h]);
      if (m_st[h] < S_PASS) done_e = 0;
      if (m_st[h] != S_PASS) pass_e = 0;
    end
    chk("rnd_all_done", all_done, done_e);
    chk("rnd_all_pass", all_pass, pass_e);
    chk("rnd_valid", trace_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("rnd_hart", trace_hart, m_q[0].hart);
      chk("rnd_from", trace_from, m_q[0].f);
      chk("rnd_to", trace_to, m_q[0].t);
    end
    chk("rnd_drops", trace_drops, m_drops);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_state"}, hart_state, 0);
    chk({tag, "_testnum"}, hart_testnum, 0);
    chk({tag, "_all_done"}, all_done, 0);
    chk({tag, "_all_pass"}, all_pass, 0);
    chk({tag, "_valid"}, trace_valid, 0);
    chk({tag, "_hart"}, trace_hart, 0);
    chk({tag, "_from"}, trace_from, 0);
    chk({tag, "_to"}, trace_to, 0);
    chk({tag, "_drops"}, trace_drops, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int en0, a0; int unsigned d0;
    int en1, a1; int unsigned d1;
    int s0, s1, dn, ps;
    int unsigned t0, t1;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [31:0] exp_from [4];

    tbl[0]  = '{1, 3, 7,   0, 0, 0,   S_RUN,  S_RUN,  0, 0, 7, 0};
    tbl[1]  = '{1, 27, 0,  1, 27, 1,  S_RUN,  S_RUN,  0, 0, 7, 0};
    tbl[2]  = '{1, 0, 5,   1, 3, 9,   S_RUN,  S_RUN,  0, 0, 7, 9};
    tbl[3]  = '{1, 26, 1,  1, 26, 1,  S_SET,  S_SET,  0, 0, 7, 9};
    tbl[4]  = '{1, 3, 8,   0, 0, 0,   S_SET,  S_SET,  0, 0, 8, 9};
    tbl[5]  = '{1, 26, 0,  0, 0, 0,   S_SET,  S_SET,  0, 0, 8, 9};
    tbl[6]  = '{0, 0, 0,   1, 0, 1,   S_SET,  S_SET,  0, 0, 8, 9};
    tbl[7]  = '{1, 27, 1,  1, 27, 0,  S_SET,  S_SET,  0, 0, 8, 9};
    tbl[8]  = '{0, 0, 0,   0, 0, 0,   S_PASS, S_FAIL, 1, 0, 8, 9};
    tbl[9]  = '{1, 3, 99,  1, 3, 5,   S_PASS, S_FAIL, 1, 0, 8, 9};
    tbl[10] = '{1, 26, 1,  1, 26, 1,  S_PASS, S_FAIL, 1, 0, 8, 9};

    // reset
    idle();
    rstn = 0;
    tick(); tick();
    check_zero("reset");
    rstn = 1;
    tick();

    // table: protocol writes, ignored x0, settle-time shadow updates, terminal hold
    do_clear();
    for (int i = 0; i < 11; i++) begin
      idle();
      if (tbl[i].en0 != 0) wr(0, tbl[i].a0, tbl[i].d0);
      if (tbl[i].en1 != 0) wr(1, tbl[i].a1, tbl[i].d1);
      tick();
      check_states($sformatf("tbl%0d", i), tbl[i].s0, tbl[i].s1);
      chk($sformatf("tbl%0d_done", i), all_done, tbl[i].dn);
      chk($sformatf("tbl%0d_pass", i), all_pass, tbl[i].ps);
      chk($sformatf("tbl%0d_tn0", i), hart_testnum[31:0], tbl[i].t0);
      chk($sformatf("tbl%0d_tn1", i), hart_testnum[63:32], tbl[i].t1);
    end

    // done at cycle 10: settle for cycles 11..15, pass at 16
    do_clear();
    for (int k = 1; k <= 10; k++) begin
      idle();
      if (k == 5)  begin wr(0, 27, 1); wr(1, 27, 1); end
      if (k == 10) begin wr(0, 26, 1); wr(1, 26, 1); end
      tick();
    end
    idle();
    for (int i = 0; i < 5; i++) begin
      check_states($sformatf("settle%0d", i), S_SET, S_SET);
      tick();
    end
    check_states("pass16", S_PASS, S_PASS);
    chk("pass16_all_pass", all_pass, 1);
    chk("pass16_all_done", all_done, 1);

    // timeout at counter 50; done write in that same cycle wins
    do_clear();
    for (int k = 0; k < 50; k++) tick();
    check_states("pre_timeout", S_RUN, S_RUN);
    wr(1, 26, 1);
    tick();
    idle();
    check_states("timeout", S_TMO, S_SET);
    chk("timeout_all_done", all_done, 0);
    for (int k = 0; k < 5; k++) tick();
    check_states("after_settle", S_TMO, S_FAIL);
    chk("after_settle_all_done", all_done, 1);
    chk("after_settle_all_pass", all_pass, 0);

    // simultaneous jumps: lowest hart kept, other counted lost
    do_clear();
    jmp(0, 32'h1000, 32'h2000);
    jmp(1, 32'h3000, 32'h4000);
    tick();
    idle();
    chk("dual_valid", trace_valid, 1);
    chk("dual_hart", trace_hart, 0);
    chk("dual_from", trace_from, 32'h1000);
    chk("dual_to", trace_to, 32'h2000);
    chk("dual_drops", trace_drops, 1);

    // overflow: 6 pushes into depth 4, then pop+push while full
    do_clear();
    for (int i = 0; i < 6; i++) begin
      idle();
      jmp(0, 32'd100 + 32'(i), 32'd200 + 32'(i));
      tick();
    end
    idle();
    chk("full_drops", trace_drops, 2);
    chk("full_head", trace_from, 100);
    jmp(0, 32'd106, 32'd206);
    trace_ready = 1;
    tick();
    idle();
    chk("poppush_drops", trace_drops, 2);
    exp_from[0] = 101; exp_from[1] = 102; exp_from[2] = 103; exp_from[3] = 106;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_valid", i), trace_valid, 1);
      chk($sformatf("drain%0d_from", i), trace_from, exp_from[i]);
      chk($sformatf("drain%0d_to", i), trace_to, exp_from[i] + 100);
      trace_ready = 1;
      tick();
    end
    chk("drained_valid", trace_valid, 0);

    // reset mid-settle with 3 queued records
    do_clear();
    for (int i = 0; i < 3; i++) begin
      idle();
      jmp(0, 32'h40 + 32'(i), 32'h80 + 32'(i));
      tick();
    end
    idle();
    wr(0, 27, 1); wr(1, 3, 42);
    tick();
    idle();
    wr(0, 26, 1); wr(1, 26, 1);
    tick();
    idle();
    check_states("pre_rst", S_SET, S_SET);
    chk("pre_rst_valid", trace_valid, 1);
    #3;
    rstn = 0;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1;
    rstn = 1;
    tick();
    check_zero("post_rst");

    // randomized run against the model
    do_clear();
    for (int c = 0; c < 3000; c++) begin
      idle();
      clear = ($urandom_range(0, 99) == 0);
      trace_ready = ($urandom_range(0, 2) == 0);
      for (int h = 0; h < NH; h++) begin
        if ($urandom_range(0, 2) == 0) begin
          int a, ds;
          logic [31:0] d;
          case ($urandom_range(0, 4))
            0: a = 0;
            1: a = 3;
            2: a = 26;
            3: a = 27;
            default: a = int'($urandom_range(0, 31));
          endcase
          ds = int'($urandom_range(0, 2));
          d = (ds == 0) ? 32'd0 : (ds == 1) ? 32'd1 : $urandom;
          wr(h, a, d);
        end
        if ($urandom_range(0, 2) == 0) jmp(h, $urandom, $urandom);
      end
      tick();
      check_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
